// File: rtl/cache_mem_responder_pkg.sv
// Shared cache-line geometry, burst state encoding and beat helpers for the memory-side responder.
package cache_mem_responder_pkg;

    localparam int ADDR_WIDTH      = 64;
    localparam int DATA_WIDTH      = 64;
    localparam int BANK_NUM        = 4;
    localparam int OFFSET_LEN      = $clog2(BANK_NUM);
    localparam int BYTE_OFFSET_LEN = $clog2(DATA_WIDTH / 8);
    localparam int OFFSET_END      = BYTE_OFFSET_LEN + OFFSET_LEN - 1;
    localparam int OFFSET_BEGIN    = OFFSET_END + 1;

    typedef logic [ADDR_WIDTH-1:0]          addr_t;
    typedef logic [DATA_WIDTH-1:0]          word_t;
    typedef logic [BANK_NUM*DATA_WIDTH-1:0] data_t;
    typedef logic [OFFSET_LEN-1:0]          beat_t;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_WAIT,
        MS_RBURST,
        MS_WBURST,
        MS_BRESP
    } mem_state_t;

    function automatic logic is_last_beat(beat_t b);
        return b == beat_t'(BANK_NUM - 1);
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Line request, writeback and refill channels between the data cache and its backing memory.
interface cache_mem_responder_if;
    import cache_mem_responder_pkg::*;

    logic  req_valid;
    logic  req_ready;
    logic  req_wen;
    addr_t req_addr;
    logic  wvalid;
    logic  wready;
    word_t wdata;
    logic  rvalid;
    logic  rready;
    word_t rdata;
    logic  rlast;
    logic  bvalid;

    modport master (
        output req_valid, req_wen, req_addr, wvalid, wdata, rready,
        input  req_ready, wready, rvalid, rdata, rlast, bvalid
    );

    modport slave (
        input  req_valid, req_wen, req_addr, wvalid, wdata, rready,
        output req_ready, wready, rvalid, rdata, rlast, bvalid
    );

endinterface

// File: rtl/cache_mem_responder_ram.sv
// Single-port word array: synchronous write, combinational read, contents never reset.
module mem_word_ram
    import cache_mem_responder_pkg::*;
#(
    parameter int MEM_WORDS = 4096
) (
    input  logic                         clk,
    input  logic                         wen,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  word_t                        wdata,
    output word_t                        rdata
);

    word_t mem [MEM_WORDS];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: one line request at a time, BANK_NUM ascending beats in or out.
// state     | meaning
// MS_IDLE   | req_ready high, waiting for a line request
// MS_WAIT   | access latency countdown
// MS_RBURST | refill beats presented on rvalid/rdata
// MS_WBURST | writeback beats accepted on wready
// MS_BRESP  | single-cycle bvalid, then back to idle
module cache_mem_responder
    import cache_mem_responder_pkg::*;
#(
    parameter int LATENCY   = 3,
    parameter int MEM_WORDS = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_mem_responder_if.slave  bus
);

    localparam int IDX_W  = $clog2(MEM_WORDS);
    localparam int LINE_W = IDX_W - OFFSET_LEN;
    localparam int LAT_W  = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    mem_state_t        state;
    beat_t             beat;
    beat_t             beat_next;
    logic [LAT_W-1:0]  lat_cnt;
    logic [LINE_W-1:0] line_base;
    logic [LINE_W-1:0] req_line;
    logic [LINE_W-1:0] ram_line;
    beat_t             ram_beat;
    logic              is_wr;
    logic              r_fire;
    logic              w_fire;
    logic              launch;
    logic              launch_wr;
    logic              ram_wen;
    word_t             ram_rdata;
    logic              unused_addr_bits;

    // Only the line bits that land inside the array matter; higher bits wrap silently.
    assign req_line         = bus.req_addr[OFFSET_BEGIN +: LINE_W];
    assign unused_addr_bits = ^{bus.req_addr[ADDR_WIDTH-1:OFFSET_BEGIN+LINE_W],
                                bus.req_addr[OFFSET_END:0]};

    assign beat_next = beat + beat_t'(1);
    assign r_fire    = bus.rvalid & bus.rready;
    assign w_fire    = bus.wready & bus.wvalid;
    assign ram_wen   = (state == MS_WBURST) & w_fire;

    // Read port looks one beat ahead so rdata can be registered on the handshake edge.
    always_comb begin
        ram_line = line_base;
        ram_beat = beat;
        case (state)
            MS_IDLE: begin
                ram_line = req_line;
                ram_beat = '0;
            end
            MS_RBURST: begin
                if (r_fire) begin
                    ram_beat = beat_next;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        launch    = 1'b0;
        launch_wr = is_wr;
        if (state == MS_IDLE) begin
            launch    = bus.req_valid && (LATENCY == 0);
            launch_wr = bus.req_wen;
        end else if (state == MS_WAIT) begin
            launch = (lat_cnt == LAT_W'(1));
        end
    end

    mem_word_ram #(
        .MEM_WORDS (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .wen   (ram_wen),
        .addr  ({ram_line, ram_beat}),
        .wdata (bus.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= MS_IDLE;
            beat          <= '0;
            lat_cnt       <= '0;
            line_base     <= '0;
            is_wr         <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.wready    <= 1'b0;
            bus.rvalid    <= 1'b0;
            bus.rlast     <= 1'b0;
            bus.bvalid    <= 1'b0;
            bus.rdata     <= '0;
        end else begin
            case (state)
                MS_IDLE: begin
                    if (bus.req_valid) begin
                        line_base     <= req_line;
                        is_wr         <= bus.req_wen;
                        lat_cnt       <= LAT_W'(LATENCY);
                        beat          <= '0;
                        bus.req_ready <= 1'b0;
                        state         <= MS_WAIT;
                    end
                end
                MS_WAIT: begin
                    lat_cnt <= lat_cnt - LAT_W'(1);
                end
                MS_RBURST: begin
                    if (r_fire) begin
                        beat <= beat_next;
                        if (is_last_beat(beat)) begin
                            state         <= MS_IDLE;
                            bus.rvalid    <= 1'b0;
                            bus.rlast     <= 1'b0;
                            bus.req_ready <= 1'b1;
                        end else begin
                            bus.rdata <= ram_rdata;
                            bus.rlast <= is_last_beat(beat_next);
                        end
                    end
                end
                MS_WBURST: begin
                    if (w_fire) begin
                        beat <= beat_next;
                        if (is_last_beat(beat)) begin
                            state      <= MS_BRESP;
                            bus.wready <= 1'b0;
                            bus.bvalid <= 1'b1;
                        end
                    end
                end
                MS_BRESP: begin
                    bus.bvalid    <= 1'b0;
                    bus.req_ready <= 1'b1;
                    state         <= MS_IDLE;
                end
                default: begin
                    state <= MS_IDLE;
                end
            endcase

            // Overrides the MS_WAIT entry above when the burst may start this edge.
            if (launch) begin
                state      <= launch_wr ? MS_WBURST : MS_RBURST;
                bus.wready <= launch_wr;
                bus.rvalid <= !launch_wr;
                if (!launch_wr) begin
                    bus.rdata <= ram_rdata;
                    bus.rlast <= is_last_beat('0);
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench: stimulus pushes expected refill beats and writeback completions, a monitor checks them.
module tb_cache_mem_responder;
    import cache_mem_responder_pkg::*;

    localparam int LAT = 3;
    localparam int MW  = 4096;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst0 = 1'b1;

    always #5 clk = ~clk;

    cache_mem_responder_if bus ();
    cache_mem_responder_if bus0 ();

    cache_mem_responder #(.LATENCY(LAT), .MEM_WORDS(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    cache_mem_responder #(.LATENCY(0), .MEM_WORDS(MW)) dut0 (
        .clk (clk),
        .rst (rst0),
        .bus (bus0)
    );

    typedef struct packed {
        word_t data;
        logic  last;
    } beat_exp_t;

    int        checks = 0;
    int        errors = 0;
    beat_exp_t exp_q[$];
    int        b_pending = 0;
    word_t     mdl [int];
    int        pool [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event expected one within the cycle budget", name);
    endtask

    // Reference word index: byte address -> word, clear bank bits, add beat, wrap to array depth.
    function automatic int widx(input addr_t a, input int b);
        addr_t w;
        w = (a >> 3) & ~addr_t'(3);
        w = w + addr_t'(b);
        return int'(w % addr_t'(MW));
    endfunction

    function automatic data_t rand_line();
        data_t d;
        for (int b = 0; b < BANK_NUM; b++) d[b*DATA_WIDTH +: DATA_WIDTH] = {$urandom(), $urandom()};
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.req_ready && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_timeout("req_ready");
    endtask

    task automatic push_line(input addr_t a);
        beat_exp_t e;
        for (int b = 0; b < BANK_NUM; b++) begin
            e.data = mdl[widx(a, b)];
            e.last = (b == BANK_NUM - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic do_write(input addr_t a, input data_t d);
        int n = 0;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b1;
        bus.req_addr  = a;
        tick();
        bus.req_valid = 1'b0;
        b_pending++;
        while (!bus.wready && n < 200) begin
            tick();
            n++;
        end
        check("write latency", 64'(n), 64'(LAT));
        for (int b = 0; b < BANK_NUM; b++) begin
            repeat ($urandom_range(0, 2)) begin
                bus.wvalid = 1'b0;
                bus.rready = 1'($urandom_range(0, 1));
                tick();
            end
            bus.rready = 1'b0;
            bus.wvalid = 1'b1;
            bus.wdata  = d[b*DATA_WIDTH +: DATA_WIDTH];
            check("wready during burst", 64'(bus.wready), 64'(1));
            tick();
            mdl[widx(a, b)] = d[b*DATA_WIDTH +: DATA_WIDTH];
        end
        bus.wvalid = 1'b0;
        check("bvalid after last beat", 64'(bus.bvalid), 64'(1));
        tick();
        check("req_ready after bresp", 64'(bus.req_ready), 64'(1));
    endtask

    // mode 0: rready always high, 1: pattern 1,0,0 repeating, 2: random
    task automatic do_read(input addr_t a, input int mode, input logic hold, input addr_t next_a);
        int n = 0;
        int hs = 0;
        int k = 0;
        logic r;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = a;
        tick();
        if (hold) bus.req_addr = next_a;
        else      bus.req_valid = 1'b0;
        push_line(a);
        while (!bus.rvalid && n < 200) begin
            tick();
            n++;
        end
        check("read latency", 64'(n), 64'(LAT));
        n = 0;
        while (hs < BANK_NUM && n < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (k % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            bus.rready = r;
            bus.wvalid = 1'($urandom_range(0, 1));
            bus.wdata  = {$urandom(), $urandom()};
            if (bus.rvalid && r) hs++;
            tick();
            k++;
            n++;
        end
        bus.rready = 1'b0;
        bus.wvalid = 1'b0;
        if (n >= 400) fail_timeout("refill beats");
        check("req_ready after last beat", 64'(bus.req_ready), 64'(1));
    endtask

    logic  prev_stall = 1'b0;
    logic  prev_b     = 1'b0;
    word_t prev_data;
    logic  prev_last;

    always @(negedge clk) begin
        beat_exp_t e;
        if (rst) begin
            prev_stall = 1'b0;
            prev_b     = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall rvalid held", 64'(bus.rvalid), 64'(1));
                check("stall rdata held", bus.rdata, prev_data);
                check("stall rlast held", 64'(bus.rlast), 64'(prev_last));
            end
            if (bus.rvalid && bus.rready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected refill beat: got %h expected none", bus.rdata);
                end else begin
                    e = exp_q.pop_front();
                    check("refill rdata", bus.rdata, e.data);
                    check("refill rlast", 64'(bus.rlast), 64'(e.last));
                end
            end
            if (bus.bvalid) begin
                check("bvalid single cycle", 64'(prev_b), 64'(0));
                check("bvalid expected", 64'(b_pending > 0), 64'(1));
                if (b_pending > 0) b_pending--;
            end
            if (bus.rvalid || bus.wready || bus.bvalid)
                check("req_ready low while busy", 64'(bus.req_ready), 64'(0));
            prev_stall = bus.rvalid && !bus.rready;
            prev_data  = bus.rdata;
            prev_last  = bus.rlast;
            prev_b     = bus.bvalid;
        end
    end

    initial begin
        addr_t a;
        data_t d0;
        data_t d1;
        int    n;
        int    bv;

        bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.rready = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_wen = 1'b0; bus0.req_addr = '0;
        bus0.wvalid = 1'b0; bus0.wdata = '0; bus0.rready = 1'b0;

        tick();
        check("reset req_ready", 64'(bus.req_ready), 64'(1));
        check("reset rvalid", 64'(bus.rvalid), 64'(0));
        check("reset wready", 64'(bus.wready), 64'(0));
        check("reset bvalid", 64'(bus.bvalid), 64'(0));
        check("reset rlast", 64'(bus.rlast), 64'(0));
        check("reset rdata", bus.rdata, 64'(0));
        rst = 1'b0;
        tick();

        do_write(addr_t'(64'h1000), {64'h44, 64'h33, 64'h22, 64'h11});
        do_read(addr_t'(64'h1000), 0, 1'b0, '0);
        do_read(addr_t'(64'h1000), 1, 1'b0, '0);

        do_write(addr_t'(MW * 8 + 32'h20), rand_line());
        do_read(addr_t'(64'h20), 2, 1'b0, '0);

        do_read(addr_t'(64'h1000), 2, 1'b1, addr_t'(64'h20));
        do_read(addr_t'(64'h20), 0, 1'b0, '0);

        for (int i = 0; i < 6; i++) begin
            pool[i] = $urandom_range(0, MW / BANK_NUM - 1) * 32;
            do_write(addr_t'(pool[i]), rand_line());
        end
        for (int i = 0; i < 30; i++) begin
            a = {$urandom(), $urandom()};
            a = (a & ~addr_t'(MW * 8 - 1)) | addr_t'(pool[$urandom_range(0, 5)]) |
                addr_t'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) do_write(a, rand_line());
            else do_read(a, $urandom_range(0, 2), 1'b0, '0);
        end

        // Asynchronous reset in the middle of a refill burst.
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_wen   = 1'b0;
        bus.req_addr  = addr_t'(pool[0]);
        tick();
        bus.req_valid = 1'b0;
        push_line(addr_t'(pool[0]));
        n = 0;
        while (!bus.rvalid && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_timeout("refill before reset");
        bus.rready = 1'b1;
        tick();
        bus.rready = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("async reset rvalid", 64'(bus.rvalid), 64'(0));
        check("async reset wready", 64'(bus.wready), 64'(0));
        check("async reset bvalid", 64'(bus.bvalid), 64'(0));
        check("async reset rlast", 64'(bus.rlast), 64'(0));
        check("async reset req_ready", 64'(bus.req_ready), 64'(1));
        exp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        tick();
        do_read(addr_t'(pool[0]), 0, 1'b0, '0);
        do_read(addr_t'(64'h1000), 1, 1'b0, '0);

        // Zero-latency instance.
        check("lat0 reset req_ready", 64'(bus0.req_ready), 64'(1));
        rst0 = 1'b0;
        tick();
        a  = addr_t'(64'h240);
        d0 = rand_line();
        d1 = rand_line();
        bus0.req_valid = 1'b1; bus0.req_wen = 1'b1; bus0.req_addr = a;
        tick();
        bus0.req_valid = 1'b0;
        check("lat0 wready after accept", 64'(bus0.wready), 64'(1));
        for (int b = 0; b < BANK_NUM; b++) begin
            bus0.wvalid = 1'b1;
            bus0.wdata  = d0[b*DATA_WIDTH +: DATA_WIDTH];
            tick();
        end
        bus0.wvalid = 1'b0;
        check("lat0 bvalid", 64'(bus0.bvalid), 64'(1));
        tick();
        check("lat0 bvalid drop", 64'(bus0.bvalid), 64'(0));
        check("lat0 req_ready after bresp", 64'(bus0.req_ready), 64'(1));

        bus0.req_valid = 1'b1; bus0.req_wen = 1'b0; bus0.req_addr = a;
        tick();
        bus0.req_valid = 1'b0;
        check("lat0 rvalid after accept", 64'(bus0.rvalid), 64'(1));
        for (int b = 0; b < BANK_NUM; b++) begin
            check("lat0 refill rdata", bus0.rdata, d0[b*DATA_WIDTH +: DATA_WIDTH]);
            check("lat0 refill rlast", 64'(bus0.rlast), 64'(b == BANK_NUM - 1));
            bus0.rready = 1'b1;
            tick();
        end
        bus0.rready = 1'b0;
        check("lat0 rvalid after burst", 64'(bus0.rvalid), 64'(0));

        bus0.req_valid = 1'b1; bus0.req_wen = 1'b1; bus0.req_addr = a;
        tick();
        bus0.req_valid = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus0.wvalid = 1'b1;
            bus0.wdata  = d1[b*DATA_WIDTH +: DATA_WIDTH];
            tick();
        end
        bus0.wvalid = 1'b1;
        bus0.wdata  = d1[2*DATA_WIDTH +: DATA_WIDTH];
        #1 rst0 = 1'b1;
        #1;
        check("lat0 reset wready", 64'(bus0.wready), 64'(0));
        check("lat0 reset req_ready", 64'(bus0.req_ready), 64'(1));
        bus0.wvalid = 1'b0;
        tick();
        rst0 = 1'b0;
        bv = 0;
        repeat (8) begin
            if (bus0.bvalid) bv++;
            tick();
        end
        check("lat0 no bvalid after reset", 64'(bv), 64'(0));

        bus0.req_valid = 1'b1; bus0.req_wen = 1'b0; bus0.req_addr = a;
        tick();
        bus0.req_valid = 1'b0;
        for (int b = 0; b < BANK_NUM; b++) begin
            check("lat0 partial writeback rdata", bus0.rdata,
                  (b < 2) ? d1[b*DATA_WIDTH +: DATA_WIDTH] : d0[b*DATA_WIDTH +: DATA_WIDTH]);
            bus0.rready = 1'b1;
            tick();
        end
        bus0.rready = 1'b0;

        tick();
        check("scoreboard drained", 64'(exp_q.size()), 64'(0));
        check("bvalid all seen", 64'(b_pending), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
